// File: rtl/seg_pkg.sv
// Shared register map, CTRL field positions and active-low glyphs for seg_display_ctrl.
// Build macro SEG_ZERO_BLANK_EN makes CTRL[16] (leading-zero blank) writable.
package seg_pkg;

    localparam logic SEG_ADDR_DATA = 1'b0;
    localparam logic SEG_ADDR_CTRL = 1'b1;

    localparam int unsigned CTRL_EN_LSB = 0;
    localparam int unsigned CTRL_DP_LSB = 8;
    localparam int unsigned CTRL_ZB_BIT = 16;

    localparam logic [31:0] CTRL_RESET = 32'h0000_00FF;

`ifdef SEG_ZERO_BLANK_EN
    localparam logic [31:0] CTRL_WMASK = 32'h0001_FFFF;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_FFFF;
`endif

    // Active-low glyphs, bit 7 (dp) held off.
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to active-low 7-segment glyph; bit 7 (dp) is always returned off.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] glyph
);

    always_comb begin
        glyph = GLYPH_0;
        unique case (nibble)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Eight-digit multiplexed hex display with frame-synchronous DATA shadowing and a CTRL register.
// Build macro SEG_ZERO_BLANK_EN adds leading-zero blanking controlled by CTRL[16].
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seg_wr,
    input  logic        seg_addr,
    input  logic [31:0] seg_wdata,
    output logic [31:0] seg_rdata,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   display_q, display_d;
    logic          pending_q, pending_d;
    logic [31:0]   ctrl_q, ctrl_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    cat_q, cat_d;

    logic          tc, commit, data_wr, ctrl_wr, blank;
    logic [7:0]    en_mask, dp_mask, glyph;
    logic [3:0]    nibble;

    assign en_mask = ctrl_q[CTRL_EN_LSB +: 8];
    assign dp_mask = ctrl_q[CTRL_DP_LSB +: 8];
    assign nibble  = display_q[{idx_q, 2'b00} +: 4];

    seg_hex_decoder u_hex_decoder (
        .nibble (nibble),
        .glyph  (glyph)
    );

    always_comb begin
        tc       = (presc_q == PRESC_MAX);
        commit   = tc && (idx_q == 3'd7);
        data_wr  = seg_wr && (seg_addr == SEG_ADDR_DATA);
        ctrl_wr  = seg_wr && (seg_addr == SEG_ADDR_CTRL);

        presc_d  = tc ? '0 : presc_q + PW'(1);
        idx_d    = tc ? idx_q + 3'd1 : idx_q;
        shadow_d = data_wr ? seg_wdata : shadow_q;
        ctrl_d   = ctrl_wr ? (seg_wdata & CTRL_WMASK) : ctrl_q;

        display_d = display_q;
        pending_d = pending_q;
        // A write landing on the commit edge bypasses the shadow so it is never lost.
        if (data_wr && commit) begin
            display_d = seg_wdata;
            pending_d = 1'b0;
        end else if (data_wr) begin
            pending_d = 1'b1;
        end else if (commit && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        blank = 1'b0;
`ifdef SEG_ZERO_BLANK_EN
        // Digit i is a leading zero when nibbles i..7 are all zero; digit 0 always shows.
        if (ctrl_q[CTRL_ZB_BIT] && (idx_q != 3'd0)) begin
            blank = ((display_q >> {idx_q, 2'b00}) == 32'd0);
        end
`endif
        an_d  = (en_mask[idx_q] && !blank) ? ~(8'd1 << idx_q) : 8'hFF;
        cat_d = glyph & {~dp_mask[idx_q], 7'h7F};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= 3'd0;
            shadow_q  <= 32'd0;
            display_q <= 32'd0;
            pending_q <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            an_q      <= 8'hFF;
            cat_q     <= 8'hFF;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            display_q <= display_d;
            pending_q <= pending_d;
            ctrl_q    <= ctrl_d;
            an_q      <= an_d;
            cat_q     <= cat_d;
        end
    end

    assign seg_an    = an_q;
    assign seg_cat   = cat_q;
    assign seg_rdata = (seg_addr == SEG_ADDR_CTRL) ? ctrl_q : shadow_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with SCAN_DIV = 4 (32-cycle frames).
module tb_seg_display_ctrl;

    localparam int unsigned SCAN_DIV = 4;

`ifdef SEG_ZERO_BLANK_EN
    localparam logic [31:0] CTRL_ALL_ONES = 32'h0001_FFFF;
    localparam logic [31:0] CTRL_ZB_FF    = 32'h0001_00FF;
`else
    localparam logic [31:0] CTRL_ALL_ONES = 32'h0000_FFFF;
    localparam logic [31:0] CTRL_ZB_FF    = 32'h0000_00FF;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seg_wr;
    logic        seg_addr;
    logic [31:0] seg_wdata;
    logic [31:0] seg_rdata;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] data;
        logic [63:0] an;   // {digit7 .. digit0}
        logic [63:0] cat;
    } disp_vec_t;

    typedef struct {
        logic        addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } rb_vec_t;

    disp_vec_t dtab [4];
    rb_vec_t   rtab [5];

    always #5 clk = ~clk;

    seg_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_wr    (seg_wr),
        .seg_addr  (seg_addr),
        .seg_wdata (seg_wdata),
        .seg_rdata (seg_rdata),
        .seg_an    (seg_an),
        .seg_cat   (seg_cat)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [31:0] d);
        seg_wr    = 1'b1;
        seg_addr  = a;
        seg_wdata = d;
        step();
        seg_wr    = 1'b0;
    endtask

    // Advance to the first cycle of the next frame (digit 0 newly on the pins).
    task automatic wait_frame_start(output logic saw_nonzero);
        int n = 0;
        saw_nonzero = 1'b0;
        while (seg_an == 8'hFE && n < 100) begin
            if (seg_cat[6:0] != 7'h40) saw_nonzero = 1'b1;
            step();
            n++;
        end
        while (seg_an != 8'hFE && n < 100) begin
            if (seg_cat[6:0] != 7'h40) saw_nonzero = 1'b1;
            step();
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_fail++;
            $display("FAIL frame_sync: got no frame start in %0d cycles, expected one", n);
        end
    endtask

    task automatic capture_frame(input string name, input logic [63:0] exp_an,
                                 input logic [63:0] exp_cat);
        for (int i = 0; i < 8; i++) begin
            if (i != 0) repeat (SCAN_DIV) step();
            check($sformatf("%s an[%0d]", name, i), {24'd0, seg_an}, {24'd0, exp_an[8*i +: 8]});
            check($sformatf("%s cat[%0d]", name, i), {24'd0, seg_cat},
                  {24'd0, exp_cat[8*i +: 8]});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic saw;
        localparam logic [63:0] AN_ALL = 64'h7FBF_DFEF_F7FB_FDFE;

        dtab[0] = '{32'h0000_00FF, 32'hFEDC_BA90, AN_ALL, 64'h8E86_A1C6_8388_90C0};
        dtab[1] = '{32'h0000_00FF, 32'h8765_4321, AN_ALL, 64'h80F8_8292_99B0_A4F9};
        dtab[2] = '{32'h0000_0105, 32'h0000_00A0, 64'hFFFF_FFFF_FFFB_FFFE,
                    64'hC0C0_C0C0_C0C0_8840};
        dtab[3] = '{32'h0000_F00F, 32'h0F0F_0F0F, 64'hFFFF_FFFF_F7FB_FDFE,
                    64'h400E_400E_C08E_C08E};

        rtab[0] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        rtab[1] = '{1'b1, 32'hFFFF_FFFF, CTRL_ALL_ONES};
        rtab[2] = '{1'b1, 32'h0001_00FF, CTRL_ZB_FF};
        rtab[3] = '{1'b1, 32'h0000_00FF, 32'h0000_00FF};
        rtab[4] = '{1'b0, 32'h0000_0000, 32'h0000_0000};

        rst_n = 1'b0;
        seg_wr = 1'b0;
        seg_addr = 1'b0;
        seg_wdata = 32'd0;

        // Reset state
        #12;
        check("rst an", {24'd0, seg_an}, 32'h0000_00FF);
        check("rst cat", {24'd0, seg_cat}, 32'h0000_00FF);
        check("rst data rb", seg_rdata, 32'd0);
        seg_addr = 1'b1;
        #1;
        check("rst ctrl rb", seg_rdata, 32'h0000_00FF);
        seg_addr = 1'b0;

        // Release: digit 0 on the first edge, digit 1 four cycles later
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rel an0", {24'd0, seg_an}, 32'h0000_00FE);
        check("rel cat0", {24'd0, seg_cat}, 32'h0000_00C0);
        repeat (3) step();
        check("rel an0 hold", {24'd0, seg_an}, 32'h0000_00FE);
        step();
        check("rel an1", {24'd0, seg_an}, 32'h0000_00FD);
        check("rel cat1", {24'd0, seg_cat}, 32'h0000_00C0);

        // Mid-frame DATA write is shadowed until the frame commit
        wr(1'b0, 32'h8765_4321);
        seg_addr = 1'b0;
        check("shadow rb", seg_rdata, 32'h8765_4321);
        wait_frame_start(saw);
        check("held until commit", {31'd0, saw}, 32'd0);
        check("commit cat0", {24'd0, seg_cat}, 32'h0000_00F9);

        // Table: CTRL + DATA, then one full frame of anodes and cathodes
        for (int r = 0; r < 4; r++) begin
            wr(1'b1, dtab[r].ctrl);
            wr(1'b0, dtab[r].data);
            wait_frame_start(saw);
            capture_frame($sformatf("row%0d", r), dtab[r].an, dtab[r].cat);
        end
        wr(1'b1, 32'h0000_00FF);

        // DATA write on the commit edge beats the earlier shadowed write
        wait_frame_start(saw);
        wr(1'b0, 32'h1111_1111);
        repeat (29) step();
        wr(1'b0, 32'hFEDC_BA98);
        wait_frame_start(saw);
        capture_frame("commit_wr", AN_ALL, 64'h8E86_A1C6_8388_9080);

        // Back-to-back writes: the last one is displayed
        wr(1'b0, 32'h1111_1111);
        wr(1'b0, 32'h0000_0003);
        wr(1'b0, 32'h0000_0025);
        wait_frame_start(saw);
        check("b2b cat0", {24'd0, seg_cat}, 32'h0000_0092);
        repeat (SCAN_DIV) step();
        check("b2b cat1", {24'd0, seg_cat}, 32'h0000_00A4);

        // CTRL[16] writability and leading-zero blanking
        wr(1'b1, 32'h0001_00FF);
        seg_addr = 1'b1;
        check("zb ctrl rb", seg_rdata, CTRL_ZB_FF);
`ifdef SEG_ZERO_BLANK_EN
        wr(1'b0, 32'h0000_00A0);
        wait_frame_start(saw);
        capture_frame("zblank", 64'hFFFF_FFFF_FFFF_FDFE, 64'hC0C0_C0C0_C0C0_88C0);
`endif
        wr(1'b1, 32'h0000_00FF);

        // Register readback table
        for (int r = 0; r < 5; r++) begin
            wr(rtab[r].addr, rtab[r].wdata);
            seg_addr = rtab[r].addr;
            #1;
            check($sformatf("rb%0d", r), seg_rdata, rtab[r].rdata);
        end

        // Asynchronous reset mid-frame with a write pending
        wr(1'b0, 32'h5555_5555);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async rst an", {24'd0, seg_an}, 32'h0000_00FF);
        check("async rst cat", {24'd0, seg_cat}, 32'h0000_00FF);
        seg_addr = 1'b0;
        #1;
        check("async rst data rb", seg_rdata, 32'd0);
        seg_wr = 1'b1;
        seg_wdata = 32'hAAAA_AAAA;
        step();
        check("wr ignored in rst data", seg_rdata, 32'd0);
        seg_addr = 1'b1;
        seg_wdata = 32'h0000_0000;
        step();
        check("wr ignored in rst ctrl", seg_rdata, 32'h0000_00FF);
        seg_wr = 1'b0;
        seg_addr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rerel an0", {24'd0, seg_an}, 32'h0000_00FE);
        check("rerel cat0", {24'd0, seg_cat}, 32'h0000_00C0);
        check("rerel data rb", seg_rdata, 32'd0);
        wait_frame_start(saw);
        check("pending dropped", {24'd0, seg_cat}, 32'h0000_00C0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each digit stays lit.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-004 SHALL have port seg_wr, input, 1, meaning the one-cycle write strobe (the CPU-side Segctrl).
REQ-005 SHALL have port seg_addr, input, 1, meaning register select: 0 = DATA, 1 = CTRL.
REQ-006 SHALL have port seg_wdata, input, 32, meaning the write data (the CPU-side write_data).
REQ-007 SHALL have port seg_rdata, output, 32, meaning a combinational readback of the register selected by seg_addr.
REQ-008 SHALL have port seg_an, output, 8, meaning digit anodes, active-low, bit i = digit i.
REQ-009 SHALL have port seg_cat, output, 8, meaning segment cathodes, active-low; [6:0] = g..a and [7] = dp.

Function
REQ-010 SHALL treat DATA as 32 bits, with nibble i shown on digit i in hexadecimal.
REQ-011 SHALL treat CTRL as follows: [7:0] = digit enable mask, [15:8] = decimal-point mask, [16] = zero-blank enable, and [31:17] ignored and read back as 0.
REQ-012 SHALL store a DATA write into a shadow register and set flag pending; the displayed value SHALL change only at a frame commit.
REQ-013 SHALL apply a CTRL write to the display on the next cycle, with no shadowing.
REQ-014 SHALL use a prescaler counting 0..SCAN_DIV-1; at the terminal count the digit index (3 bits) SHALL advance and wrap 7 -> 0.
REQ-015 SHALL define a frame commit as the cycle where the prescaler is at terminal count and the digit index is 7; if pending, shadow -> display and pending is cleared.
REQ-016 SHALL, on a DATA write in the commit cycle, load the new seg_wdata directly into the display register and clear pending (the write wins).
REQ-017 SHALL register seg_an and seg_cat, giving one cycle of latency from the digit index to the pins.
REQ-018 SHALL drive a one-hot-low anode for the current digit if its enable-mask bit is 1, and otherwise seg_an = 8'hFF.
REQ-019 SHALL set seg_cat[7] = ~dp_mask[index] and set seg_cat[6:0] to the hex glyph of the current nibble.
REQ-020 SHALL return the shadow register (not the display register) on a DATA readback; the CTRL readback SHALL return the CTRL register.
REQ-021 SHALL ignore writes while rst_n is low.
REQ-022 SHALL accept back-to-back writes on every cycle; the last DATA write before a commit is the one displayed.

Reset
REQ-023 SHALL, while rst_n is low: seg_an = 8'hFF, seg_cat = 8'hFF, DATA shadow/display = 0, CTRL = 32'h0000_00FF, pending = 0, prescaler = 0, index = 0.
REQ-024 SHALL drive seg_an = 8'hFE showing digit 0 on the first rising edge after rst_n deasserts.
REQ-025 SHALL, on reset asserted mid-frame, clear all state immediately, drop any pending write, and turn all anodes off.

Configuration
REQ-026 SHALL use macro SEG_ZERO_BLANK_EN to enable leading-zero blanking.
REQ-027 SHALL, when SEG_ZERO_BLANK_EN is defined and CTRL[16] = 1, blank every digit above the highest nonzero nibble by forcing its anode off; digit 0 is never blanked.
REQ-028 SHALL, when SEG_ZERO_BLANK_EN is undefined, make CTRL[16] unwritable (reads as 0) and include no blanking logic.

Structure
REQ-029 SHALL place in a shared package seg_pkg: register offsets, the CTRL field positions, the CTRL reset value, and the active-low glyph constants (e.g. 0 = 8'hC0, 1 = 8'hF9).
REQ-030 SHALL use one sub-module, seg_hex_decoder, a combinational 4-bit nibble to 7-segment active-low decoder.
REQ-031 SHALL leave address decoding (the comparison against SEG_BASE_ADDR) upstream; this block sees only seg_wr and seg_addr.

Verification (bench uses SCAN_DIV = 4)
REQ-032 SHALL cover: release reset -> seg_an = FE, seg_cat = C0, and the next digit appears after 4 cycles.
REQ-033 SHALL cover: DATA write 32'h8765_4321 mid-frame -> the display stays 0 until after the digit-7 terminal count, then digit 0 shows seg_cat = F9; DATA readback = 8765_4321 immediately.
REQ-034 SHALL cover: a DATA write exactly in the commit cycle -> the new value is shown in the next frame and pending = 0.
REQ-035 SHALL cover: CTRL write 32'h0000_0105 -> only digits 0 and 2 light, and digit 0 has seg_cat[7] = 0.
REQ-036 SHALL cover, with SEG_ZERO_BLANK_EN defined, CTRL = 0x1_00FF and DATA = 0x0000_00A0 -> only digits 0-1 light; with the macro undefined, CTRL readback = 0x00FF.
REQ-037 SHALL cover: rst_n pulled low mid-frame with pending = 1 -> outputs go to FF asynchronously, and after release DATA readback = 0.
